// File: rtl/video_std_detect_pkg.sv
// Shared constants for video standard detection: chip codes, measurement class
// encoding, detector FSM states and the edge-count classifier.
package video_std_detect_pkg;

  localparam logic [1:0] CHIP6569   = 2'b00;
  localparam logic [1:0] CHIP6567R8 = 2'b01;

  typedef logic [1:0] std_class_t;
  localparam std_class_t CLS_NONE = 2'd0;
  localparam std_class_t CLS_NTSC = 2'd1;
  localparam std_class_t CLS_PAL  = 2'd2;

  localparam logic [0:0] ST_ACQUIRE = 1'b0;
  localparam logic [0:0] ST_LOCKED  = 1'b1;

  // A count in the gap between the two ranges is deliberately unclassifiable.
  function automatic std_class_t classify_count(input logic [7:0] n,
                                                input int ntsc_min, input int ntsc_max,
                                                input int pal_min, input int pal_max);
    int v;
    v = int'(n);
    if (v >= ntsc_min && v <= ntsc_max) return CLS_NTSC;
    if (v >= pal_min && v <= pal_max)   return CLS_PAL;
    return CLS_NONE;
  endfunction

  function automatic logic [1:0] class_to_chip(input std_class_t cls);
    return (cls == CLS_NTSC) ? CHIP6567R8 : CHIP6569;
  endfunction

endpackage

// File: rtl/video_std_detect_sync.sv
// Two-flop synchroniser for an asynchronous strap/clock input followed by a
// registered rising-edge pulse (pulse appears 3 cycles after the input edge).
module sync_rise_detect (
  input  logic sys_clock,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge sys_clock) begin
    if (!rst_n) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      sync_p2    <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      // p0/p1: metastability filter; p2: previous value for edge detection
      sync_p0    <= async_in;
      sync_p1    <= sync_p0;
      sync_p2    <= sync_p1;
      rise_pulse <= sync_p1 & ~sync_p2;
    end
  end

endmodule

// File: rtl/video_std_detect.sv
// Measures the pre-divided video oscillator over fixed sys_clock windows and
// commits the implied chip model after several consecutive agreeing windows.
module video_std_detect
  import video_std_detect_pkg::*;
#(
  parameter int         WINDOW_CYCLES  = 50000,
  parameter int         NTSC_MIN       = 50,
  parameter int         NTSC_MAX       = 62,
  parameter int         PAL_MIN        = 64,
  parameter int         PAL_MAX        = 76,
  parameter int         STABLE_WINDOWS = 4,
  parameter int         LOSS_WINDOWS   = 3,
  parameter logic [1:0] DEFAULT_CHIP   = CHIP6569
) (
  input  logic       sys_clock,
  input  logic       rst_n,
  input  logic       osc_div,
  output logic [1:0] chip,
  output logic       is_pal,
  output logic       std_valid,
  output logic       std_changed,
  output logic [7:0] edge_count
);

  localparam int WCNT_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int AGR_W  = $clog2(STABLE_WINDOWS + 1);
  localparam int LOSS_W = $clog2(LOSS_WINDOWS + 1);

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW_CYCLES - 1);
  localparam logic [AGR_W-1:0]  AGR_MAX   = AGR_W'(STABLE_WINDOWS);
  localparam logic [LOSS_W-1:0] LOSS_MAX  = LOSS_W'(LOSS_WINDOWS);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [AGR_W-1:0] sat_inc_agree(input logic [AGR_W-1:0] v);
    return (v >= AGR_MAX) ? AGR_MAX : v + AGR_W'(1);
  endfunction

  function automatic logic [LOSS_W-1:0] sat_inc_loss(input logic [LOSS_W-1:0] v);
    return (v >= LOSS_MAX) ? LOSS_MAX : v + LOSS_W'(1);
  endfunction

  logic              rise;
  logic [WCNT_W-1:0] wcnt;
  logic [7:0]        ecnt;
  logic [AGR_W-1:0]  agree;
  logic [LOSS_W-1:0] loss;
  std_class_t        prev_cls;
  logic [0:0]        state;

  logic              term;
  logic [7:0]        final_cnt;
  std_class_t        cls;
  logic [AGR_W-1:0]  agree_nxt;
  logic [LOSS_W-1:0] loss_nxt;
  logic              commit;
  logic              drop;

  sync_rise_detect u_sync (
    .sys_clock  (sys_clock),
    .rst_n      (rst_n),
    .async_in   (osc_div),
    .rise_pulse (rise)
  );

  // Window-close decision, evaluated every cycle but only acted on at term
  always_comb begin
    term      = (wcnt == WCNT_LAST);
    final_cnt = rise ? sat_inc8(ecnt) : ecnt;
    cls       = classify_count(final_cnt, NTSC_MIN, NTSC_MAX, PAL_MIN, PAL_MAX);
    agree_nxt = '0;
    loss_nxt  = '0;
    if (cls == CLS_NONE) begin
      loss_nxt = sat_inc_loss(loss);
    end else if (cls == prev_cls) begin
      agree_nxt = sat_inc_agree(agree);
    end else begin
      agree_nxt = AGR_W'(1);
    end
    commit = (agree_nxt == AGR_MAX) &&
             ((state == ST_ACQUIRE) || (chip != class_to_chip(cls)));
    drop   = (state == ST_LOCKED) && (loss_nxt == LOSS_MAX);
  end

  always_ff @(posedge sys_clock) begin
    if (!rst_n) begin
      wcnt        <= '0;
      ecnt        <= '0;
      agree       <= '0;
      loss        <= '0;
      prev_cls    <= CLS_NONE;
      state       <= ST_ACQUIRE;
      chip        <= DEFAULT_CHIP;
      is_pal      <= (DEFAULT_CHIP == CHIP6569);
      std_valid   <= 1'b0;
      std_changed <= 1'b0;
      edge_count  <= '0;
    end else begin
      std_changed <= 1'b0;
      if (term) begin
        wcnt       <= '0;
        ecnt       <= '0;
        edge_count <= final_cnt;
        agree      <= agree_nxt;
        loss       <= loss_nxt;
        prev_cls   <= cls;
        if (commit) begin
          chip        <= class_to_chip(cls);
          is_pal      <= (cls == CLS_PAL);
          std_valid   <= 1'b1;
          std_changed <= 1'b1;
          state       <= ST_LOCKED;
        end else if (drop) begin
          std_valid <= 1'b0;
          state     <= ST_ACQUIRE;
        end
      end else begin
        wcnt <= wcnt + WCNT_W'(1);
        if (rise) ecnt <= sat_inc8(ecnt);
      end
    end
  end

endmodule

// File: tb/tb_video_std_detect.sv
// Window-level bench for video_std_detect: drives a known number of osc_div
// edges per window and compares outputs with a per-window reference model.
module tb_video_std_detect;
  import video_std_detect_pkg::*;

  localparam int W   = 640;
  localparam int OFF = 16;

  logic       sys_clock = 1'b0;
  logic       rst_n     = 1'b0;
  logic       osc_div   = 1'b0;
  logic [1:0] chip;
  logic       is_pal;
  logic       std_valid;
  logic       std_changed;
  logic [7:0] edge_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_prev;
  int         m_agree;
  int         m_loss;
  bit         m_locked;
  logic [1:0] m_chip;
  bit         m_pulse;
  int         m_edges;

  video_std_detect #(.WINDOW_CYCLES(W)) dut (
    .sys_clock   (sys_clock),
    .rst_n       (rst_n),
    .osc_div     (osc_div),
    .chip        (chip),
    .is_pal      (is_pal),
    .std_valid   (std_valid),
    .std_changed (std_changed),
    .edge_count  (edge_count)
  );

  always #10 sys_clock = ~sys_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_agree = 0; m_loss = 0; m_locked = 0;
    m_chip = CHIP6569; m_pulse = 0; m_edges = 0;
  endtask

  // 0 = unclassifiable, 1 = NTSC (14.318 MHz), 2 = PAL (17.734 MHz)
  function automatic int std_of(input int n);
    if (n >= 50 && n <= 62) return 1;
    if (n >= 64 && n <= 76) return 2;
    return 0;
  endfunction

  task automatic model_window(input int n);
    int c;
    logic [1:0] want;
    m_edges = (n > 255) ? 255 : n;
    c = std_of(m_edges);
    if (c == 0) begin
      m_agree = 0;
      m_loss  = (m_loss < 3) ? m_loss + 1 : 3;
    end else begin
      m_agree = (c == m_prev) ? ((m_agree < 4) ? m_agree + 1 : 4) : 1;
      m_loss  = 0;
    end
    m_prev  = c;
    m_pulse = 0;
    want    = (c == 1) ? CHIP6567R8 : CHIP6569;
    if (m_agree == 4 && (!m_locked || m_chip != want)) begin
      m_chip = want; m_locked = 1; m_pulse = 1;
    end else if (m_locked && m_loss == 3) begin
      m_locked = 0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_chip"},    32'(chip),        32'(CHIP6569));
    check({tag, "_is_pal"},  32'(is_pal),      32'd1);
    check({tag, "_valid"},   32'(std_valid),   32'd0);
    check({tag, "_changed"}, 32'(std_changed), 32'd0);
    check({tag, "_edges"},   32'(edge_count),  32'd0);
  endtask

  // One full window with n rising edges of the given period; rst_at >= 0
  // aborts the window with a one-cycle reset at that cycle.
  task automatic run_window(input int n, input int period, input int rst_at);
    for (int c = 0; c < W; c++) begin
      osc_div = (c >= OFF && c < OFF + n * period && ((c - OFF) % period) < period / 2);
      if (c == rst_at) begin
        rst_n   = 1'b0;
        osc_div = 1'b0;
        @(posedge sys_clock); #1;
        check_reset_values("midreset");
        rst_n = 1'b1;
        model_reset();
        return;
      end
      @(posedge sys_clock); #1;
      if (c == 0 || c == W / 2) check("pulse_width", 32'(std_changed), 32'd0);
    end
    osc_div = 1'b0;
    model_window(n);
    check("edge_count", 32'(edge_count),  32'(m_edges));
    check("chip",       32'(chip),        32'(m_chip));
    check("is_pal",     32'(is_pal),      32'(m_chip == CHIP6569));
    check("std_valid",  32'(std_valid),   32'(m_locked));
    check("std_changed",32'(std_changed), 32'(m_pulse));
  endtask

  task automatic run_n(input int n, input int count);
    for (int i = 0; i < count; i++) run_window(n, 4, -1);
  endtask

  initial begin
    int pick;
    int n;
    int reps;
    int period;
    int picks [10] = '{56, 69, 62, 64, 63, 50, 76, 49, 77, 0};
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge sys_clock);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    run_n(69, 4);   // PAL acquisition
    run_n(56, 4);   // switch to NTSC while locked
    run_n(0, 3);    // loss of signal
    run_n(56, 4);   // relock

    run_window(0, 4, W / 2);  // clean restart for boundary tests
    run_n(62, 4);
    run_n(63, 3);
    run_n(64, 4);
    run_n(76, 2);
    run_n(77, 3);
    run_window(256, 2, -1);   // saturating count
    for (int i = 0; i < 8; i++) run_window((i % 2) ? 64 : 62, 4, -1);

    run_n(69, 2);             // reset two windows into acquisition
    run_window(69, 4, W / 3);
    run_n(69, 4);

    for (int i = 0; i < 12; i++) begin
      pick   = $urandom_range(0, 10);
      n      = (pick == 10) ? $urandom_range(0, 100) : picks[pick];
      reps   = $urandom_range(1, 5);
      period = $urandom_range(2, 5);
      for (int r = 0; r < reps; r++) run_window(n, period, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
